// File: rtl/pool_pkg.sv
// Shared defaults and row type for the pooling write-back path.
package pool_pkg;

  localparam int unsigned PoolDataWidth = 16;
  localparam int unsigned PoolCol       = 32;

  // One full row: element j holds column j.
  typedef logic [PoolCol-1:0][PoolDataWidth-1:0] pool_row_t;

endpackage

// File: rtl/pool_wb_fifo.sv
// Row-wide FIFO for the pooling write-back path; a push while full succeeds only when a pop
// happens in the same cycle.
module pool_wb_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PtrW + 1)'(Depth));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the read side is only trusted while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pool_writeback.sv
// Deskews per-column pooled values into whole rows and queues them for a ready/valid consumer.
// Build option: define POOL_WB_RELU_EN to clamp negative captured values to zero.
module pool_writeback
  import pool_pkg::*;
#(
  parameter int unsigned data_width = PoolDataWidth,
  parameter int unsigned col        = PoolCol,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned row_idx_w  = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            clear,
  input  logic [col-1:0]                  pool_done,
  input  logic [col-1:0][data_width-1:0]  pool_data,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [col-1:0][data_width-1:0]  out_data,
  output logic [row_idx_w-1:0]            out_row_idx,
  output logic                            overflow,
  output logic                            busy
);

  localparam int unsigned RowW   = col * data_width;
  localparam int unsigned EntryW = RowW + row_idx_w;

  logic [col-1:0]                       r_par;
  logic [col-1:0][1:0]                  r_pend;
  logic [col-1:0][1:0][data_width-1:0]  r_slot;
  logic                                 r_complete;
  logic                                 r_cpar;
  logic                                 r_overflow;
  logic [row_idx_w-1:0]                 r_row_cnt;

  logic [col-1:0][data_width-1:0] w_cap_val;
  logic [col-1:0][data_width-1:0] w_row;
  logic [col-1:0]                 w_slot_clash;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_pop;
  logic                           w_push_ok;
  logic                           w_drop;
  logic [EntryW-1:0]              w_head;

  always_comb begin
    w_cap_val    = '0;
    w_row        = '0;
    w_slot_clash = '0;
    for (int unsigned j = 0; j < col; j++) begin
`ifdef POOL_WB_RELU_EN
      w_cap_val[j] = pool_data[j][data_width-1] ? '0 : pool_data[j];
`else
      w_cap_val[j] = pool_data[j];
`endif
      w_row[j] = r_slot[j][r_cpar];
      // Writing an occupied slot is only safe if that slot is being drained on this same edge.
      w_slot_clash[j] = pool_done[j] && r_pend[j][r_par[j]] &&
                        !(r_complete && (r_cpar == r_par[j]));
    end
  end

  assign w_pop     = !w_empty && out_ready;
  assign w_push_ok = r_complete && (!w_full || w_pop);
  assign w_drop    = r_complete && w_full && !w_pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_par      <= '0;
      r_pend     <= '0;
      r_slot     <= '0;
      r_complete <= 1'b0;
      r_cpar     <= 1'b0;
      r_overflow <= 1'b0;
      r_row_cnt  <= '0;
    end else if (clear) begin
      r_par      <= '0;
      r_pend     <= '0;
      r_slot     <= '0;
      r_complete <= 1'b0;
      r_cpar     <= 1'b0;
      r_overflow <= 1'b0;
      r_row_cnt  <= '0;
    end else begin
      r_complete <= pool_done[col-1];
      r_cpar     <= r_par[col-1];
      for (int unsigned j = 0; j < col; j++) begin
        if (r_complete) r_pend[j][r_cpar] <= 1'b0;
        if (pool_done[j]) begin
          r_slot[j][r_par[j]] <= w_cap_val[j];
          r_pend[j][r_par[j]] <= 1'b1;
          r_par[j]            <= ~r_par[j];
        end
      end
      if ((|w_slot_clash) || w_drop) r_overflow <= 1'b1;
      if (w_push_ok) r_row_cnt <= r_row_cnt + row_idx_w'(1);
    end
  end

  pool_wb_fifo #(
    .Width (EntryW),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (clear),
    .i_push  (r_complete),
    .i_data  ({w_row, r_row_cnt}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? '0 : w_head[EntryW-1:row_idx_w];
  assign out_row_idx = w_empty ? '0 : w_head[row_idx_w-1:0];
  assign overflow    = r_overflow;
  assign busy        = (|r_pend) || !w_empty;

endmodule

// File: tb/tb_pool_writeback.sv
// Self-checking bench for pool_writeback: planned directed phases plus a randomized phase,
// checked every cycle against a row-level queue model.
module tb_pool_writeback;
  import pool_pkg::*;

  localparam int unsigned Col   = PoolCol;
  localparam int unsigned Dw    = PoolDataWidth;
  localparam int unsigned Depth = 4;
  localparam int          NMax  = 3000;

  logic            clk = 1'b0;
  logic            nrst;
  logic            clear;
  logic [Col-1:0]  pool_done;
  pool_row_t       pool_data;
  logic            out_ready;
  logic            out_valid;
  pool_row_t       out_data;
  logic [7:0]      out_row_idx;
  logic            overflow;
  logic            busy;

  always #5 clk = ~clk;

  pool_writeback #(
    .data_width (Dw),
    .col        (Col),
    .fifo_depth (Depth),
    .row_idx_w  (8)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .clear       (clear),
    .pool_done   (pool_done),
    .pool_data   (pool_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_row_idx (out_row_idx),
    .overflow    (overflow),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Planned stimulus, indexed by cycle.
  logic [Col-1:0] s_done [NMax];
  pool_row_t      s_data [NMax];
  logic           s_rst  [NMax];
  logic           s_clr  [NMax];
  logic           s_rdy  [NMax];

  task automatic sched_row(input int start, input pool_row_t vals, input int ncols);
    for (int j = 0; j < ncols; j++) begin
      s_done[start+j][j] = 1'b1;
      s_data[start+j][j] = vals[j];
    end
  endtask

  task automatic set_rdy(input int a, input int b, input logic v);
    for (int c = a; c <= b; c++) s_rdy[c] = v;
  endtask

  function automatic pool_row_t rand_row();
    pool_row_t r;
    for (int j = 0; j < Col; j++) r[j] = 16'($urandom);
    return r;
  endfunction

  function automatic logic [Dw-1:0] relu(input logic [Dw-1:0] v);
`ifdef POOL_WB_RELU_EN
    return v[Dw-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Row-level model: per-column queues of captured values, and a bounded queue of finished rows.
  logic [Dw-1:0] cb   [Col][4];
  int            cb_n [Col];
  pool_row_t     q_data [$];
  logic [7:0]    q_idx  [$];
  logic          m_ovf;
  logic          m_pend;
  pool_row_t     m_row;
  logic [7:0]    m_cnt;
  logic          m_rst_state;

  task automatic model_step();
    if (!nrst || clear) begin
      for (int j = 0; j < Col; j++) cb_n[j] = 0;
      q_data.delete();
      q_idx.delete();
      m_ovf = 1'b0;
      m_pend = 1'b0;
      m_cnt = 8'd0;
      m_rst_state = 1'b1;
    end else begin
      m_rst_state = 1'b0;
      if (q_data.size() > 0 && out_ready) begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
      end
      if (m_pend) begin
        if (q_data.size() < Depth) begin
          q_data.push_back(m_row);
          q_idx.push_back(m_cnt);
          m_cnt = m_cnt + 8'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_pend = 1'b0;
      for (int j = 0; j < Col; j++) begin
        if (pool_done[j]) begin
          if (cb_n[j] >= 2) m_ovf = 1'b1;
          if (cb_n[j] < 4) begin
            cb[j][cb_n[j]] = relu(pool_data[j]);
            cb_n[j]++;
          end
        end
      end
      if (pool_done[Col-1]) begin
        m_pend = 1'b1;
        for (int j = 0; j < Col; j++) begin
          m_row[j] = (cb_n[j] > 0) ? cb[j][0] : '0;
          for (int i = 0; i < 3; i++) cb[j][i] = cb[j][i+1];
          if (cb_n[j] > 0) cb_n[j]--;
        end
      end
    end
  endtask

  task automatic compare();
    logic m_busy;
    m_busy = m_pend || (q_data.size() > 0);
    for (int j = 0; j < Col; j++) if (cb_n[j] > 0) m_busy = 1'b1;
    chk("out_valid", out_valid, q_data.size() > 0);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_busy);
    if (q_data.size() > 0) begin
      chk("out_data", out_data, q_data[0]);
      chk("out_row_idx", out_row_idx, q_idx[0]);
    end
    if (m_rst_state) begin
      chk("out_data_rst", out_data, '0);
      chk("out_row_idx_rst", out_row_idx, '0);
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  initial begin
    pool_row_t expa;
    pool_row_t rowv;
    pool_row_t flat;
    logic [Dw-1:0] exp_e0;
    int st, prev1, prev2, ncyc;

    nrst = 1'b0;
    clear = 1'b0;
    pool_done = '0;
    pool_data = '0;
    out_ready = 1'b0;

    for (int c = 0; c < NMax; c++) begin
      s_done[c] = '0;
      s_data[c] = '0;
      s_rst[c]  = 1'b0;
      s_clr[c]  = 1'b0;
      s_rdy[c]  = 1'b1;
    end
    for (int c = 0; c < 5; c++) s_rst[c] = 1'b1;

    // Single row, values j+1.
    for (int j = 0; j < Col; j++) expa[j] = 16'(j + 1);
    sched_row(10, expa, Col);
    // Back-to-back rows.
    s_clr[55] = 1'b1;
    sched_row(60, rand_row(), Col);
    sched_row(61, rand_row(), Col);
    // Stalled consumer, five rows: fifth is dropped.
    s_clr[110] = 1'b1;
    set_rdy(110, 349, 1'b0);
    for (int k = 0; k < 5; k++) sched_row(120 + 40 * k, rand_row(), Col);
    // FIFO full with push and pop in the same cycle.
    s_clr[400] = 1'b1;
    set_rdy(400, 649, 1'b0);
    s_rdy[602] = 1'b1;
    for (int k = 0; k < 4; k++) sched_row(410 + 40 * k, rand_row(), Col);
    sched_row(570, rand_row(), Col);
    // Reset after column 15, then a full row with a negative value in column 0.
    sched_row(700, rand_row(), 16);
    s_rst[717] = 1'b1;
    s_rst[718] = 1'b1;
    rowv = rand_row();
    rowv[0] = 16'h8001;
    sched_row(730, rowv, Col);
    // Three rows one cycle apart with equal values: column slots get overwritten.
    s_clr[800] = 1'b1;
    for (int j = 0; j < Col; j++) flat[j] = 16'h0005;
    for (int k = 0; k < 3; k++) sched_row(810 + k, flat, Col);
    // Random rows; any row and the one two after it start at least 34 cycles apart.
    s_clr[900] = 1'b1;
    prev1 = -100;
    prev2 = -100;
    st = 910;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) st = prev1 + int'($urandom_range(1, 40));
      if (st < prev2 + 34) st = prev2 + 34;
      sched_row(st, rand_row(), Col);
      prev2 = prev1;
      prev1 = st;
    end
    ncyc = st + 32 + 60;
    for (int c = 900; c < st + 33; c++) s_rdy[c] = ($urandom_range(0, 9) < 7);

`ifdef POOL_WB_RELU_EN
    exp_e0 = 16'h0000;
`else
    exp_e0 = 16'h8001;
`endif

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (c)
        3: begin
          chk("rst_valid", out_valid, 1'b0);
          chk("rst_data", out_data, '0);
          chk("rst_idx", out_row_idx, 8'd0);
          chk("rst_overflow", overflow, 1'b0);
          chk("rst_busy", busy, 1'b0);
        end
        42: chk("a_valid_early", out_valid, 1'b0);
        43: begin
          chk("a_valid", out_valid, 1'b1);
          chk("a_data", out_data, expa);
          chk("a_idx", out_row_idx, 8'd0);
        end
        93: chk("b_idx0", {out_valid, out_row_idx}, {1'b1, 8'd0});
        94: chk("b_idx1", {out_valid, out_row_idx}, {1'b1, 8'd1});
        100: chk("b_overflow", overflow, 1'b0);
        340: chk("c_full", {overflow, out_valid, out_row_idx}, {1'b1, 1'b1, 8'd0});
        353: chk("c_idx3", out_row_idx, 8'd3);
        354: chk("c_drained", out_valid, 1'b0);
        640: chk("d_pushpop", {overflow, out_valid, out_row_idx}, {1'b0, 1'b1, 8'd1});
        653: chk("d_idx4", out_row_idx, 8'd4);
        716: chk("e_busy_partial", busy, 1'b1);
        718: chk("e_in_reset", {out_valid, overflow, busy, out_row_idx, out_data},
                 {3'b000, 8'd0, 512'd0});
        763: begin
          chk("e_idx", {out_valid, out_row_idx}, {1'b1, 8'd0});
          chk("e_relu", out_data[0], exp_e0);
        end
        850: chk("f_overwrite", overflow, 1'b1);
        default: ;
      endcase
      nrst      = !s_rst[c];
      clear     = s_clr[c];
      pool_done = s_done[c];
      pool_data = s_data[c];
      out_ready = s_rdy[c];
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
